// File: rtl/debug_frame_tx.sv
// Debug-frame serializer: snapshots a wide debug vector on trigger and streams
// header, data bytes (word0 first, MSB byte first) and an 8-bit additive checksum to uart_tx.
module debug_frame_tx #(
  parameter int unsigned NUM_WORDS = 4,
  parameter logic [7:0]  HDR_BYTE  = 8'hA5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      trigger,
  input  logic [32*NUM_WORDS-1:0]   snap_data,
  input  logic                      tx_done_tick,
  output logic                      tx_start,
  output logic [7:0]                tx_data,
  output logic                      busy,
  output logic                      frame_done_tick
);

  localparam int unsigned NUM_BYTES = 4 * NUM_WORDS;
  localparam int unsigned IDX_W     = $clog2(NUM_BYTES) + 1;
  localparam logic [IDX_W-1:0] DATA_END = IDX_W'(NUM_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                   state;
  logic [IDX_W-1:0]         idx;
  logic [7:0]               csum;
  logic [32*NUM_WORDS-1:0]  snap_q;
  logic [7:0]               cur_byte;

  // Byte idx maps to word idx/4, byte lane 3-(idx%4) so each word goes out MSB first.
  always_comb begin
    cur_byte = '0;
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_byte = snap_q[32*(i/4) + 8*(3-(i%4)) +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      idx             <= '0;
      csum            <= '0;
      snap_q          <= '0;
      tx_start        <= 1'b0;
      tx_data         <= '0;
      busy            <= 1'b0;
      frame_done_tick <= 1'b0;
    end else begin
      tx_start        <= 1'b0;
      frame_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (trigger) begin
            snap_q   <= snap_data;
            csum     <= '0;
            idx      <= '0;
            busy     <= 1'b1;
            tx_data  <= HDR_BYTE;
            tx_start <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (tx_done_tick) begin
            // frame_done_tick/busy are registered here so they are visible during DONE.
            if (idx == LAST_IDX) begin
              state           <= DONE;
              busy            <= 1'b0;
              frame_done_tick <= 1'b1;
            end else begin
              state <= SEND;
            end
          end
        end
        SEND: begin
          if (idx < DATA_END) begin
            tx_data <= cur_byte;
            csum    <= csum + cur_byte;
          end else begin
            tx_data <= csum;
          end
          idx      <= idx + IDX_W'(1);
          tx_start <= 1'b1;
          state    <= WAIT;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_frame_tx.sv
// Bench for debug_frame_tx (NUM_WORDS=2): a uart_tx responder answers each tx_start
// with tx_done_tick ~10 cycles later; captured bytes are compared with a frame model.
module tb_debug_frame_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        trigger;
  logic [63:0] snap_data;
  logic        tx_done_tick;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;
  logic        frame_done_tick;

  int vectors = 0;
  int errs    = 0;

  int cyc = 0;
  int cd  = 0;
  logic       pending = 1'b0;
  logic [7:0] hold    = '0;
  int stab_err = 0;
  int busy_err = 0;

  logic [7:0] bytes_q[$];
  int         start_cyc[$];
  int         tick_cyc[$];
  int         done_cyc[$];

  debug_frame_tx #(.NUM_WORDS(2), .HDR_BYTE(8'hA5)) dut (
    .clk             (clk),
    .reset           (reset),
    .trigger         (trigger),
    .snap_data       (snap_data),
    .tx_done_tick    (tx_done_tick),
    .tx_start        (tx_start),
    .tx_data         (tx_data),
    .busy            (busy),
    .frame_done_tick (frame_done_tick)
  );

  always #5 clk = ~clk;

  // Monitor first, then act as uart_tx: one tick 10 cycles after each tx_start.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      pending      = 1'b0;
      cd           = 0;
      tx_done_tick = 1'b0;
    end else begin
      if (pending && tx_data !== hold) stab_err = stab_err + 1;
      if (tx_done_tick) pending = 1'b0;
      if (tx_start) begin
        bytes_q.push_back(tx_data);
        start_cyc.push_back(cyc);
        hold    = tx_data;
        pending = 1'b1;
        if (!busy) busy_err = busy_err + 1;
      end
      if (frame_done_tick) done_cyc.push_back(cyc);
      tx_done_tick = 1'b0;
      if (cd > 0) begin
        cd = cd - 1;
        if (cd == 0) begin
          tx_done_tick = 1'b1;
          tick_cyc.push_back(cyc);
        end
      end
      if (tx_start) cd = 10;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: header, each word's bytes high to low, sum of data bytes mod 256.
  function automatic void build_frame(input logic [63:0] snap, output logic [7:0] f [10]);
    int          sum;
    int unsigned word;
    int unsigned b;
    sum  = 0;
    f[0] = 8'hA5;
    for (int w = 0; w < 2; w++) begin
      word = snap[32*w +: 32];
      for (int k = 0; k < 4; k++) begin
        b = (word >> (24 - 8*k)) % 256;
        f[1 + 4*w + k] = b[7:0];
        sum = (sum + int'(b)) % 256;
      end
    end
    f[9] = sum[7:0];
  endfunction

  task automatic check_frame(input string tag, input logic [63:0] snap, input int base);
    logic [7:0] f [10];
    logic [7:0] obs;
    build_frame(snap, f);
    for (int i = 0; i < 10; i++) begin
      obs = (base + i < bytes_q.size()) ? bytes_q[base + i] : 8'hxx;
      check($sformatf("%s_byte%0d", tag, i), {24'h0, obs}, {24'h0, f[i]});
    end
  endtask

  task automatic clear_logs();
    bytes_q.delete();
    start_cyc.delete();
    tick_cyc.delete();
    done_cyc.delete();
  endtask

  task automatic wait_frames(input string tag, input int n, input int budget);
    int seen = 0;
    int k    = 0;
    while (seen < n && k < budget) begin
      @(negedge clk);
      if (frame_done_tick) seen++;
      k++;
    end
    check({tag, "_frame_wait"}, seen, n);
  endtask

  task automatic run_frame(input string tag, input logic [63:0] snap);
    @(negedge clk);
    clear_logs();
    snap_data = snap;
    trigger   = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    wait_frames(tag, 1, 400);
    repeat (3) @(negedge clk);
    check({tag, "_len"}, bytes_q.size(), 10);
    check_frame(tag, snap, 0);
  endtask

  initial begin
    logic [7:0]  t1 [10];
    logic [63:0] s;
    int          n_before;
    int          d_before;

    reset     = 1'b1;
    trigger   = 1'b0;
    snap_data = '0;
    tx_done_tick = 1'b0;
    #1;
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done_tick, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: directed frame with fixed expected bytes and handshake timing
    t1 = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h38};
    run_frame("t1", {32'h0A0B0C0D, 32'h01020304});
    for (int i = 0; i < 10; i++)
      check($sformatf("t1_direct%0d", i), {24'h0, (i < bytes_q.size()) ? bytes_q[i] : 8'hxx}, {24'h0, t1[i]});
    check("t1_done_after_tick", done_cyc.size() > 0 && tick_cyc.size() == 10 ? done_cyc[0] - tick_cyc[9] : -1, 1);
    check("t1_byte_gap", start_cyc.size() > 1 && tick_cyc.size() > 0 ? start_cyc[1] - tick_cyc[0] : -1, 2);
    check("t1_idle_busy", busy, 0);

    // 2: all ones, checksum wraps to F8
    run_frame("t2", {64{1'b1}});
    check("t2_checksum", {24'h0, (bytes_q.size() == 10) ? bytes_q[9] : 8'hxx}, 32'hF8);

    // 3: trigger re-pulsed mid-frame is ignored
    @(negedge clk);
    clear_logs();
    s = {$urandom, $urandom};
    snap_data = s;
    trigger   = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    for (int k = 0; k < 200 && bytes_q.size() < 4; k++) @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    check("t3_busy_mid", busy, 1);
    wait_frames("t3", 1, 400);
    repeat (40) @(negedge clk);
    check("t3_len", bytes_q.size(), 10);
    check("t3_one_done", done_cyc.size(), 1);
    check_frame("t3", s, 0);

    // 4: reset while waiting on byte 5 aborts silently
    @(negedge clk);
    clear_logs();
    snap_data = {$urandom, $urandom};
    trigger   = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    for (int k = 0; k < 200 && bytes_q.size() < 5; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("t4_abort_tx_start", tx_start, 0);
    check("t4_abort_tx_data", tx_data, 0);
    check("t4_abort_busy", busy, 0);
    check("t4_abort_done", frame_done_tick, 0);
    @(negedge clk);
    reset = 1'b0;
    n_before = bytes_q.size();
    d_before = done_cyc.size();
    repeat (40) @(negedge clk);
    check("t4_no_more_bytes", bytes_q.size(), n_before);
    check("t4_no_done", done_cyc.size(), d_before);
    run_frame("t4_after", {$urandom, $urandom});

    // 5: trigger held high gives back-to-back identical frames
    @(negedge clk);
    clear_logs();
    s = {$urandom, $urandom};
    snap_data = s;
    trigger   = 1'b1;
    wait_frames("t5", 2, 800);
    trigger = 1'b0;
    repeat (30) @(negedge clk);
    check("t5_len", bytes_q.size(), 20);
    check_frame("t5_f1", s, 0);
    check_frame("t5_f2", s, 10);
    check("t5_restart_gap", start_cyc.size() > 10 && done_cyc.size() > 0 ? start_cyc[10] - done_cyc[0] : -1, 2);

    // 6: snap_data scrambled every cycle after acceptance
    @(negedge clk);
    clear_logs();
    s = {$urandom, $urandom};
    snap_data = s;
    trigger   = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    for (int k = 0; k < 400 && done_cyc.size() == 0; k++) begin
      snap_data = {$urandom, $urandom};
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("t6_len", bytes_q.size(), 10);
    check_frame("t6", s, 0);

    // random frames
    for (int r = 0; r < 4; r++) run_frame($sformatf("rnd%0d", r), {$urandom, $urandom});

    check("tx_data_stable", stab_err, 0);
    check("busy_during_tx", busy_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
